// File: rtl/reg_file_traced_pkg.sv
// Shared definitions for the traced register file: default widths, trace
// record width helper and replay FSM state encoding.
package reg_file_traced_pkg;

  localparam int ADDR_W_DEF      = 5;
  localparam int DATA_W_DEF      = 32;
  localparam int TRACE_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // Record = {ra1, ra2, rd1, rd2, wa, wd, write}
  function automatic int trace_rec_w(input int aw, input int dw);
    return 3 * aw + 3 * dw + 1;
  endfunction

  localparam int TRACE_REC_W = trace_rec_w(ADDR_W_DEF, DATA_W_DEF);

endpackage

// File: rtl/reg_file_traced_trace_fifo.sv
// Synchronous trace FIFO; a push into a full FIFO is still accepted when a
// pop happens on the same edge.
module trace_fifo
  import reg_file_traced_pkg::*;
#(
  parameter int W     = TRACE_REC_W,
  parameter int DEPTH = TRACE_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_traced.sv
// 32x32 MIPS register file (2 read, 1 write, r0 hardwired to zero) with a
// trace FIFO replayed as one-cycle pulses separated by at least one low cycle.
module reg_file_traced
  import reg_file_traced_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TRACE_DEPTH = TRACE_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              trace_valid,
  output logic [ADDR_W-1:0] trace_addr1,
  output logic [ADDR_W-1:0] trace_addr2,
  output logic [ADDR_W-1:0] trace_addr3,
  output logic [DATA_W-1:0] trace_data1,
  output logic [DATA_W-1:0] trace_data2,
  output logic [DATA_W-1:0] trace_data3,
  output logic              trace_write,
  output logic              trace_pulse,
  output logic              trace_ovf,
  output state_t            dbg_state
);

  localparam int REC_W = trace_rec_w(ADDR_W, DATA_W);
  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];
  state_t            r_state;
  state_t            w_next_state;
  logic              w_pop;
  logic              w_pulse_next;
  logic              w_wr;
  logic              w_full;
  logic              w_empty;
  logic [REC_W-1:0]  w_rec;
  logic [REC_W-1:0]  w_dout;

  assign w_wr = we && (wa != '0);

  // Reads bypass the write port so a same-cycle write is visible immediately.
  always_comb begin
    rd1 = r_regs[ra1];
    rd2 = r_regs[ra2];
    if (ra1 == '0)                  rd1 = '0;
    else if (w_wr && (wa == ra1))   rd1 = wd;
    if (ra2 == '0)                  rd2 = '0;
    else if (w_wr && (wa == ra2))   rd2 = wd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[wa] <= wd;
    end
  end

  assign w_rec = {ra1, ra2, rd1, rd2, wa, wd, w_wr};

  trace_fifo #(
    .W     (REC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (trace_valid),
    .pop   (w_pop),
    .din   (w_rec),
    .full  (w_full),
    .empty (w_empty),
    .dout  (w_dout)
  );

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_pulse_next = 1'b0;
    case (r_state)
      IDLE, LOW: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_pulse_next = 1'b1;
          w_next_state = HIGH;
        end else begin
          w_next_state = IDLE;
        end
      end
      HIGH:    w_next_state = LOW;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      trace_pulse <= 1'b0;
      trace_ovf   <= 1'b0;
      trace_addr1 <= '0;
      trace_addr2 <= '0;
      trace_addr3 <= '0;
      trace_data1 <= '0;
      trace_data2 <= '0;
      trace_data3 <= '0;
      trace_write <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      trace_pulse <= w_pulse_next;
      if (trace_valid && w_full && !w_pop) trace_ovf <= 1'b1;
      if (w_pop) begin
        {trace_addr1, trace_addr2, trace_data1, trace_data2,
         trace_addr3, trace_data3, trace_write} <= w_dout;
      end
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_reg_file_traced.sv
// Directed bench for reg_file_traced: register table, trace latency/rate,
// overflow and reset-mid-replay sequences.
module tb_reg_file_traced;
  import reg_file_traced_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ra1, ra2, wa;
  logic [31:0] rd1, rd2, wd;
  logic        we, trace_valid;
  logic [4:0]  trace_addr1, trace_addr2, trace_addr3;
  logic [31:0] trace_data1, trace_data2, trace_data3;
  logic        trace_write, trace_pulse, trace_ovf;
  state_t      dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          k;
  logic        prev_pulse = 1'b0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          cyc_q[$];

  reg_file_traced dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .we(we), .wa(wa), .wd(wd), .trace_valid(trace_valid),
    .trace_addr1(trace_addr1), .trace_addr2(trace_addr2), .trace_addr3(trace_addr3),
    .trace_data1(trace_data1), .trace_data2(trace_data2), .trace_data3(trace_data3),
    .trace_write(trace_write), .trace_pulse(trace_pulse), .trace_ovf(trace_ovf),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: one sample per low phase; a pulse two samples in a row is a fault.
  always @(negedge clk) begin
    if (trace_pulse) begin
      got_q.push_back(trace_data3);
      cyc_q.push_back(cyc);
      n_tests++;
      if (prev_pulse) begin
        n_fail++;
        $display("FAIL pulse_width: pulse high on consecutive cycles at cycle %0d, required one-cycle pulse", cyc);
      end
    end
    prev_pulse = trace_pulse;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; trace_valid = 1'b0;
  endtask

  task automatic chk_queue(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_rec%0d", name, i), got_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd0,  32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 5'd5,  32'h00000001, 5'd5,  5'd31, 32'h00000001, 32'hA5A5A5A5};
    vecs[6] = '{1'b0, 5'd5,  32'hFFFF0000, 5'd5,  5'd31, 32'h00000001, 32'hA5A5A5A5};
    vecs[7] = '{1'b1, 5'd31, 32'h0,        5'd1,  5'd31, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd5,  32'h0,        32'h00000001};
    vecs[9] = '{1'b1, 5'd3,  32'h33333333, 5'd3,  5'd4,  32'h33333333, 32'h0};

    idle_inputs();
    reset = 1'b1;
    ra1 = 5'd5; ra2 = 5'd31;
    repeat (3) tick();
    chk("reset_rd1", rd1, 32'h0);
    chk("reset_rd2", rd2, 32'h0);
    chk("reset_pulse", 32'(trace_pulse), 32'h0);
    chk("reset_ovf", 32'(trace_ovf), 32'h0);
    chk("reset_data3", trace_data3, 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    tick();

    // Register file table: reads checked combinationally before each write edge.
    for (int i = 0; i < 10; i++) begin
      we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
      ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
      #2;
      chk($sformatf("vec%0d_rd1", i), rd1, vecs[i].exp_rd1);
      chk($sformatf("vec%0d_rd2", i), rd2, vecs[i].exp_rd2);
      tick();
    end
    idle_inputs();
    tick();

    // Traced write to r0 never reports as a write.
    we = 1'b1; wa = 5'd0; wd = 32'h12345678; ra1 = 5'd5; ra2 = 5'd31; trace_valid = 1'b1;
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("r0_trace_write", 32'(trace_write), 32'h0);
    chk("r0_trace_data3", trace_data3, 32'h12345678);
    chk("r0_trace_data1", trace_data1, 32'h00000001);
    chk("r0_trace_addr3", 32'(trace_addr3), 32'd0);

    // Single record: pulse one edge after capture, low the edge after.
    we = 1'b1; wa = 5'd7; wd = 32'hFFFFFFFF; ra1 = 5'd3; ra2 = 5'd4; trace_valid = 1'b1;
    tick();
    idle_inputs();
    chk("single_no_pulse_at_k", 32'(trace_pulse), 32'h0);
    tick();
    chk("single_pulse_k1", 32'(trace_pulse), 32'h1);
    chk("single_data3", trace_data3, 32'hFFFFFFFF);
    chk("single_data1", trace_data1, 32'h33333333);
    chk("single_data2", trace_data2, 32'h0);
    chk("single_addr1", 32'(trace_addr1), 32'd3);
    chk("single_addr2", 32'(trace_addr2), 32'd4);
    chk("single_addr3", 32'(trace_addr3), 32'd7);
    chk("single_write", 32'(trace_write), 32'h1);
    tick();
    chk("single_pulse_k2", 32'(trace_pulse), 32'h0);
    chk("single_data3_held", trace_data3, 32'hFFFFFFFF);
    ra1 = 5'd7;
    #1;
    chk("r7_written", rd1, 32'hFFFFFFFF);
    idle_inputs();
    repeat (4) tick();

    // Three back-to-back records: pulses at k+1, k+3, k+5.
    got_q.delete(); cyc_q.delete(); exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      wa = 5'(i + 1); wd = 32'h500 + 32'(i); trace_valid = 1'b1;
      exp_q.push_back(32'h500 + 32'(i));
      tick();
      if (i == 0) k = cyc;
    end
    idle_inputs();
    repeat (8) tick();
    chk_queue("burst3");
    for (int i = 0; i < 3 && i < cyc_q.size(); i++)
      chk($sformatf("burst3_edge%0d", i), 32'(cyc_q[i] - k), 32'(2 * i + 1));
    chk("burst3_ovf", 32'(trace_ovf), 32'h0);

    // Ten back-to-back records into a 4-deep FIFO drained every other cycle:
    // the 8th push lands on a full FIFO with a pop (kept), the 9th is dropped.
    got_q.delete(); cyc_q.delete(); exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      wa = 5'(i + 1); wd = 32'h600 + 32'(i); trace_valid = 1'b1;
      if (i != 8) exp_q.push_back(32'h600 + 32'(i));
      tick();
      if (i == 7) chk("ovf_full_push_pop", 32'(trace_ovf), 32'h0);
      if (i == 8) chk("ovf_set_on_drop", 32'(trace_ovf), 32'h1);
    end
    idle_inputs();
    repeat (25) tick();
    chk_queue("burst10");
    chk("ovf_sticky", 32'(trace_ovf), 32'h1);

    // Reset while a pulse is high abandons the record and clears everything.
    got_q.delete(); cyc_q.delete();
    for (int i = 0; i < 2; i++) begin
      wd = 32'h700 + 32'(i); trace_valid = 1'b1;
      tick();
    end
    idle_inputs();
    chk("pre_reset_pulse", 32'(trace_pulse), 32'h1);
    reset = 1'b1;
    #1;
    chk("reset_kills_pulse", 32'(trace_pulse), 32'h0);
    chk("reset_clears_ovf", 32'(trace_ovf), 32'h0);
    got_q.delete();
    repeat (2) tick();
    reset = 1'b0;
    exp_q.delete();
    repeat (8) tick();
    chk_queue("after_reset");
    ra1 = 5'd5; ra2 = 5'd7;
    #1;
    chk("after_reset_rd1", rd1, 32'h0);
    chk("after_reset_rd2", rd2, 32'h0);
    chk("after_reset_data3", trace_data3, 32'h0);
    chk("after_reset_state", 32'(dbg_state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
